hazard_ctrl_unit: RTL and testbench
===================================

Name: hazard_ctrl_unit

Overview:
- Pipeline sequencing controller for the 5-stage RISC-V core.
- Decides every cycle whether each pipeline register advances, holds or is flushed. Covers load-use stalls, taken branch/jump redirects, and multi-cycle data-memory waits.
- Complements operand forwarding, which handles the remaining RAW hazards without stalling.
- Keeps a memory-wait watchdog and stall/flush performance counters.

Parameters:
- MEM_TIMEOUT, 255, maximum consecutive MEM_WAIT cycles before the error flag sets (range 1..65535).
- CNT_W, 16, width of the performance counters.

Ports:
- clk  in  1  core clock
- reset  in  1  synchronous, active-high reset
- Rs1_ID  in  5  rs1 of the instruction in ID
- Rs2_ID  in  5  rs2 of the instruction in ID
- Rs2_used_ID  in  1  ID instruction reads rs2 (R/S/B types)
- RD_EX  in  5  destination register of the instruction in EX
- MemRead_EX  in  1  instruction in EX is a load
- Redirect_EX  in  1  taken branch or jump resolved in EX
- MemReq_MEM  in  1  MEM-stage instruction accesses data memory
- MemReady  in  1  data memory completes the access this cycle
- PC_Write  out  1  PC loads its next value
- IF_ID_Write  out  1  IF/ID register loads
- IF_ID_Flush  out  1  IF/ID register cleared to NOP
- ID_EX_Flush  out  1  ID/EX control fields cleared (bubble)
- EX_MEM_Write  out  1  EX/MEM register loads
- MEM_WB_Write  out  1  MEM/WB register loads
- MemTimeoutErr  out  1  sticky watchdog error
- StallCnt  out  CNT_W  cycles with PC_Write=0
- FlushCnt  out  CNT_W  redirects taken

Behaviour:
- Output timing:
  - State and counters are registered on the clk rising edge.
  - Control outputs are combinational from state and current inputs, so they are valid in the same cycle.
- Reset (sampled at the clock edge while reset=1):
  - State goes to RUN; wait counter=0; MemTimeoutErr=0; StallCnt=0; FlushCnt=0.
  - While reset=1, outputs are forced: PC_Write=0, IF_ID_Write=0, IF_ID_Flush=1, ID_EX_Flush=1, EX_MEM_Write=0, MEM_WB_Write=0.
  - Reset in the middle of MEM_WAIT aborts the wait with no residue.
- Hazard terms:
  - load_use = MemRead_EX & RD_EX!=0 & (Rs1_ID==RD_EX | (Rs2_used_ID & Rs2_ID==RD_EX)).
  - Register x0 never causes a hazard.
  - mem_busy = MemReq_MEM & ~MemReady.
- States: RUN, MEM_WAIT.
- RUN transitions:
  - mem_busy → MEM_WAIT.
  - Otherwise stay in RUN.
- MEM_WAIT transitions:
  - MemReady → RUN.
  - Reset → RUN.
- Output priority, highest first:
  1. mem_busy (in either state):
     - All Write outputs = 0; both flush outputs = 0; the whole pipe freezes.
     - A pending redirect or load-use is held, not lost, because EX is frozen. It is re-evaluated after release.
  2. Redirect_EX:
     - IF_ID_Flush=1, ID_EX_Flush=1; PC_Write=1 (target is loaded); all other Write outputs = 1.
     - Redirect overrides load_use, since the ID instruction is squashed.
     - FlushCnt increments once per cycle in which this rule is applied.
  3. load_use:
     - PC_Write=0, IF_ID_Write=0, ID_EX_Flush=1; EX_MEM_Write=1, MEM_WB_Write=1.
     - Exactly one bubble is inserted. The load advances to MEM, so the condition clears on the next cycle and no extra state is needed.
  4. Default:
     - All Write outputs = 1; both flush outputs = 0.
- In the MemReady cycle (mem_busy=0), outputs follow rules 2–4 in that same cycle; there is no dead cycle.
- Watchdog:
  - The wait counter increments each MEM_WAIT cycle and clears on return to RUN.
  - When the counter reaches MEM_TIMEOUT, MemTimeoutErr sets. It stays set until reset.
  - The pipeline keeps waiting; the error does not force a release.
- Counters:
  - StallCnt increments each non-reset cycle with PC_Write=0.
  - Both counters saturate at all-ones; they do not wrap.

Decomposition:
- Shared core package (hazard_pkg):
  - State encoding constants: RUN=1'b0, MEM_WAIT=1'b1.
  - REG_ZERO=5'd0.
- Natural sub-module: sat_counter, a saturating counter with parameterised width and increment enable. Instantiate it twice, for StallCnt and FlushCnt.
- Hazard detection and output decode stay in the top module.

Test Plan:
- Reset:
  - Stimulus: hold reset=1 for 2 cycles, with random inputs applied.
  - Response: PC_Write=0, IF_ID_Flush=ID_EX_Flush=1, StallCnt=0, FlushCnt=0, MemTimeoutErr=0. Run state after release.
- Load-use:
  - Stimulus: MemRead_EX=1, RD_EX=5, Rs1_ID=5.
  - Response: exactly one cycle of PC_Write=0, IF_ID_Write=0, ID_EX_Flush=1. StallCnt=1.
  - Repeat with RD_EX=0 → no stall.
  - Repeat with Rs2_ID=5 and Rs2_used_ID=0 → no stall.
- Redirect beats load-use:
  - Stimulus: Redirect_EX=1 and load_use true in the same cycle.
  - Response: IF_ID_Flush=1, ID_EX_Flush=1, PC_Write=1. FlushCnt increments by 1, StallCnt unchanged.
- Memory wait:
  - Stimulus: MemReq_MEM=1, MemReady=0 for 4 cycles, with Redirect_EX=1 throughout, then MemReady=1.
  - Response: all Write outputs=0 and no flushes for 4 cycles. The redirect flush is applied in the MemReady cycle. StallCnt=4, FlushCnt=1.
- Watchdog:
  - Stimulus: MEM_TIMEOUT=3, MemReady held at 0.
  - Response: MemTimeoutErr rises after the 3rd MEM_WAIT cycle and stays set after MemReady=1. Only reset clears it.
- Saturation:
  - Stimulus: CNT_W=4, 20 load-use stalls.
  - Response: StallCnt holds at 15.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard controller: state encoding,
// register-zero constant and the per-cycle pipeline control bundle.
package hazard_pkg;

   typedef enum logic {
      RUN      = 1'b0,
      MEM_WAIT = 1'b1
   } state_e;

   localparam logic [4:0] REG_ZERO = 5'd0;

   // Pipeline register controls decided every cycle
   typedef struct packed {
      logic pc_write;
      logic if_id_write;
      logic if_id_flush;
      logic id_ex_flush;
      logic ex_mem_write;
      logic mem_wb_write;
   } ctrl_t;

   localparam ctrl_t CTRL_RESET    = '{pc_write: 1'b0, if_id_write: 1'b0, if_id_flush: 1'b1,
                                       id_ex_flush: 1'b1, ex_mem_write: 1'b0, mem_wb_write: 1'b0};
   localparam ctrl_t CTRL_FREEZE   = '{pc_write: 1'b0, if_id_write: 1'b0, if_id_flush: 1'b0,
                                       id_ex_flush: 1'b0, ex_mem_write: 1'b0, mem_wb_write: 1'b0};
   localparam ctrl_t CTRL_REDIRECT = '{pc_write: 1'b1, if_id_write: 1'b1, if_id_flush: 1'b1,
                                       id_ex_flush: 1'b1, ex_mem_write: 1'b1, mem_wb_write: 1'b1};
   localparam ctrl_t CTRL_LOAD_USE = '{pc_write: 1'b0, if_id_write: 1'b0, if_id_flush: 1'b0,
                                       id_ex_flush: 1'b1, ex_mem_write: 1'b1, mem_wb_write: 1'b1};
   localparam ctrl_t CTRL_RUN      = '{pc_write: 1'b1, if_id_write: 1'b1, if_id_flush: 1'b0,
                                       id_ex_flush: 1'b0, ex_mem_write: 1'b1, mem_wb_write: 1'b1};

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
   parameter int unsigned W = 16
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         i_inc,
   output logic [W-1:0] o_count
);

   logic [W-1:0] r_count;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_count <= '0;
      end else if (i_inc && (r_count != {W{1'b1}})) begin
         r_count <= r_count + W'(1);
      end
   end

   assign o_count = r_count;

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Pipeline sequencing controller: load-use stalls, redirect flushes,
// data-memory wait freeze with watchdog, and stall/flush counters.
module hazard_ctrl_unit
   import hazard_pkg::*;
#(
   parameter int unsigned MEM_TIMEOUT = 255,
   parameter int unsigned CNT_W       = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [4:0]       Rs1_ID,
   input  logic [4:0]       Rs2_ID,
   input  logic             Rs2_used_ID,
   input  logic [4:0]       RD_EX,
   input  logic             MemRead_EX,
   input  logic             Redirect_EX,
   input  logic             MemReq_MEM,
   input  logic             MemReady,
   output logic             PC_Write,
   output logic             IF_ID_Write,
   output logic             IF_ID_Flush,
   output logic             ID_EX_Flush,
   output logic             EX_MEM_Write,
   output logic             MEM_WB_Write,
   output logic             MemTimeoutErr,
   output logic [CNT_W-1:0] StallCnt,
   output logic [CNT_W-1:0] FlushCnt
);

   localparam int unsigned WAIT_W = 16;

   logic              w_load_use;
   logic              w_mem_busy;
   ctrl_t             w_ctrl;
   logic              w_stall_inc;
   logic              w_flush_inc;
   logic [WAIT_W:0]   w_wait_inc;
   state_e            r_state;
   logic [WAIT_W-1:0] r_wait_cnt;
   logic              r_timeout_err;

   assign w_load_use = MemRead_EX && (RD_EX != REG_ZERO) &&
                       ((Rs1_ID == RD_EX) || (Rs2_used_ID && (Rs2_ID == RD_EX)));
   assign w_mem_busy = MemReq_MEM && !MemReady;

   // Priority decode; a busy memory freezes everything so EX-stage requests are held
   always_comb begin
      w_ctrl = CTRL_RUN;
      if (reset) begin
         w_ctrl = CTRL_RESET;
      end else if (w_mem_busy) begin
         w_ctrl = CTRL_FREEZE;
      end else if (Redirect_EX) begin
         w_ctrl = CTRL_REDIRECT;
      end else if (w_load_use) begin
         w_ctrl = CTRL_LOAD_USE;
      end
   end

   assign w_stall_inc = !reset && !w_ctrl.pc_write;
   assign w_flush_inc = !reset && !w_mem_busy && Redirect_EX;
   assign w_wait_inc  = {1'b0, r_wait_cnt} + (WAIT_W+1)'(1);

   // Wait-state tracking and watchdog; the error never releases the pipe
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state       <= RUN;
         r_wait_cnt    <= '0;
         r_timeout_err <= 1'b0;
      end else if (r_state == RUN) begin
         r_wait_cnt <= '0;
         if (w_mem_busy) begin
            r_state <= MEM_WAIT;
         end
      end else if (MemReady) begin
         r_state    <= RUN;
         r_wait_cnt <= '0;
      end else begin
         if (r_wait_cnt != WAIT_W'(MEM_TIMEOUT)) begin
            r_wait_cnt <= w_wait_inc[WAIT_W-1:0];
         end
         if (w_wait_inc >= (WAIT_W+1)'(MEM_TIMEOUT)) begin
            r_timeout_err <= 1'b1;
         end
      end
   end

   sat_counter #(.W(CNT_W)) u_stall_cnt (
      .clk     (clk),
      .reset   (reset),
      .i_inc   (w_stall_inc),
      .o_count (StallCnt)
   );

   sat_counter #(.W(CNT_W)) u_flush_cnt (
      .clk     (clk),
      .reset   (reset),
      .i_inc   (w_flush_inc),
      .o_count (FlushCnt)
   );

   assign PC_Write      = w_ctrl.pc_write;
   assign IF_ID_Write   = w_ctrl.if_id_write;
   assign IF_ID_Flush   = w_ctrl.if_id_flush;
   assign ID_EX_Flush   = w_ctrl.id_ex_flush;
   assign EX_MEM_Write  = w_ctrl.ex_mem_write;
   assign MEM_WB_Write  = w_ctrl.mem_wb_write;
   assign MemTimeoutErr = r_timeout_err;

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Bench for hazard_ctrl_unit: a default instance and a small one
// (MEM_TIMEOUT=3, CNT_W=4) share stimulus and are checked against a model.
module tb_hazard_ctrl_unit;

   typedef struct packed {
      logic       rst;
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic       rs2u;
      logic [4:0] rd;
      logic       memrd;
      logic       redir;
      logic       mreq;
      logic       mrdy;
   } stim_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset = 1'b1;
   logic [4:0] Rs1_ID = '0, Rs2_ID = '0, RD_EX = '0;
   logic       Rs2_used_ID = 1'b0, MemRead_EX = 1'b0, Redirect_EX = 1'b0;
   logic       MemReq_MEM = 1'b0, MemReady = 1'b0;

   logic        u0_pc, u0_ifw, u0_iff, u0_idf, u0_exw, u0_wbw, u0_err;
   logic [15:0] u0_stall, u0_flush;
   logic        u1_pc, u1_ifw, u1_iff, u1_idf, u1_exw, u1_wbw, u1_err;
   logic [3:0]  u1_stall, u1_flush;

   hazard_ctrl_unit u0 (
      .clk(clk), .reset(reset), .Rs1_ID(Rs1_ID), .Rs2_ID(Rs2_ID), .Rs2_used_ID(Rs2_used_ID),
      .RD_EX(RD_EX), .MemRead_EX(MemRead_EX), .Redirect_EX(Redirect_EX),
      .MemReq_MEM(MemReq_MEM), .MemReady(MemReady),
      .PC_Write(u0_pc), .IF_ID_Write(u0_ifw), .IF_ID_Flush(u0_iff), .ID_EX_Flush(u0_idf),
      .EX_MEM_Write(u0_exw), .MEM_WB_Write(u0_wbw), .MemTimeoutErr(u0_err),
      .StallCnt(u0_stall), .FlushCnt(u0_flush)
   );

   hazard_ctrl_unit #(.MEM_TIMEOUT(3), .CNT_W(4)) u1 (
      .clk(clk), .reset(reset), .Rs1_ID(Rs1_ID), .Rs2_ID(Rs2_ID), .Rs2_used_ID(Rs2_used_ID),
      .RD_EX(RD_EX), .MemRead_EX(MemRead_EX), .Redirect_EX(Redirect_EX),
      .MemReq_MEM(MemReq_MEM), .MemReady(MemReady),
      .PC_Write(u1_pc), .IF_ID_Write(u1_ifw), .IF_ID_Flush(u1_iff), .ID_EX_Flush(u1_idf),
      .EX_MEM_Write(u1_exw), .MEM_WB_Write(u1_wbw), .MemTimeoutErr(u1_err),
      .StallCnt(u1_stall), .FlushCnt(u1_flush)
   );

   int n_assert = 0;
   int n_fail   = 0;

   // Reference model state, index 0 = default instance, 1 = small instance
   int m_stall[2]   = '{0, 0};
   int m_flush[2]   = '{0, 0};
   int m_waiting[2] = '{0, 0};
   int m_waited[2]  = '{0, 0};
   int m_err[2]     = '{0, 0};
   int cnt_max[2]   = '{65535, 15};
   int timeout[2]   = '{255, 3};

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // {PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, EX_MEM_Write, MEM_WB_Write}
   function automatic logic [5:0] exp_ctrl(input stim_t s);
      bit hit_rs1, hit_rs2, load_use, busy;
      hit_rs1  = (s.rs1 == s.rd);
      hit_rs2  = s.rs2u && (s.rs2 == s.rd);
      load_use = s.memrd && (s.rd != 5'd0) && (hit_rs1 || hit_rs2);
      busy     = s.mreq && !s.mrdy;
      if (s.rst)           return 6'b001100;
      else if (busy)       return 6'b000000;
      else if (s.redir)    return 6'b111111;
      else if (load_use)   return 6'b000111;
      else                 return 6'b110011;
   endfunction

   // Apply one cycle of stimulus, check against the model, then advance the model
   task automatic tick(input stim_t s, input bit chk_regs = 1'b1);
      logic [5:0] e;
      bit busy;
      @(negedge clk);
      reset = s.rst; Rs1_ID = s.rs1; Rs2_ID = s.rs2; Rs2_used_ID = s.rs2u; RD_EX = s.rd;
      MemRead_EX = s.memrd; Redirect_EX = s.redir; MemReq_MEM = s.mreq; MemReady = s.mrdy;
      #1;
      e = exp_ctrl(s);
      chk("u0_ctrl", 32'({u0_pc, u0_ifw, u0_iff, u0_idf, u0_exw, u0_wbw}), 32'(e));
      chk("u1_ctrl", 32'({u1_pc, u1_ifw, u1_iff, u1_idf, u1_exw, u1_wbw}), 32'(e));
      if (chk_regs) begin
         chk("u0_stall", 32'(u0_stall), 32'(m_stall[0]));
         chk("u0_flush", 32'(u0_flush), 32'(m_flush[0]));
         chk("u0_err",   32'(u0_err),   32'(m_err[0]));
         chk("u1_stall", 32'(u1_stall), 32'(m_stall[1]));
         chk("u1_flush", 32'(u1_flush), 32'(m_flush[1]));
         chk("u1_err",   32'(u1_err),   32'(m_err[1]));
      end
      busy = s.mreq && !s.mrdy;
      for (int i = 0; i < 2; i++) begin
         if (s.rst) begin
            m_stall[i] = 0; m_flush[i] = 0; m_waiting[i] = 0; m_waited[i] = 0; m_err[i] = 0;
         end else begin
            if (!e[5] && m_stall[i] < cnt_max[i]) m_stall[i]++;
            if (!busy && s.redir && m_flush[i] < cnt_max[i]) m_flush[i]++;
            if (m_waiting[i] == 0) begin
               m_waited[i] = 0;
               if (busy) m_waiting[i] = 1;
            end else if (s.mrdy) begin
               m_waiting[i] = 0;
               m_waited[i]  = 0;
            end else begin
               m_waited[i]++;
               if (m_waited[i] >= timeout[i]) m_err[i] = 1;
            end
         end
      end
   endtask

   function automatic stim_t mk(input bit rst, input int rs1, input int rs2, input bit rs2u,
                                input int rd, input bit memrd, input bit redir,
                                input bit mreq, input bit mrdy);
      stim_t s;
      s.rst = rst; s.rs1 = 5'(rs1); s.rs2 = 5'(rs2); s.rs2u = rs2u; s.rd = 5'(rd);
      s.memrd = memrd; s.redir = redir; s.mreq = mreq; s.mrdy = mrdy;
      return s;
   endfunction

   function automatic stim_t rnd(input bit allow_rst);
      stim_t s;
      s.rst   = allow_rst && ($urandom_range(0, 49) == 0);
      s.rs1   = 5'($urandom_range(0, 3));
      s.rs2   = 5'($urandom_range(0, 3));
      s.rs2u  = 1'($urandom_range(0, 1));
      s.rd    = 5'($urandom_range(0, 3));
      s.memrd = 1'($urandom_range(0, 1));
      s.redir = ($urandom_range(0, 3) == 0);
      s.mreq  = ($urandom_range(0, 2) == 0);
      s.mrdy  = ($urandom_range(0, 3) != 0);
      return s;
   endfunction

   stim_t idle;
   stim_t s;

   initial begin
      idle = mk(0, 1, 2, 1, 3, 0, 0, 0, 1);

      // Reset with random inputs
      s = rnd(0); s.rst = 1'b1; tick(s, 1'b0);
      s = rnd(0); s.rst = 1'b1; tick(s, 1'b1);
      tick(idle);
      chk("run_after_reset_pc", 32'(u0_pc), 32'd1);

      // Load-use on rs1: one bubble
      tick(mk(0, 5, 0, 0, 5, 1, 0, 0, 1));
      chk("ld_use_pc", 32'(u0_pc), 32'd0);
      chk("ld_use_idex_flush", 32'(u0_idf), 32'd1);
      tick(idle);
      chk("ld_use_one_cycle", 32'(u0_pc), 32'd1);
      chk("ld_use_stallcnt", 32'(u0_stall), 32'd1);

      // x0 destination and unused rs2 never stall
      tick(mk(0, 0, 0, 1, 0, 1, 0, 0, 1));
      chk("x0_no_stall", 32'(u0_pc), 32'd1);
      tick(mk(0, 3, 5, 0, 5, 1, 0, 0, 1));
      chk("rs2_unused_no_stall", 32'(u0_pc), 32'd1);
      tick(mk(0, 3, 5, 1, 5, 1, 0, 0, 1));
      chk("rs2_used_stall", 32'(u0_pc), 32'd0);

      // Redirect beats load-use
      s = rnd(0); s.rst = 1'b1; tick(s);
      tick(mk(0, 5, 0, 0, 5, 1, 1, 0, 1));
      chk("redir_ifid_flush", 32'(u0_iff), 32'd1);
      chk("redir_pc", 32'(u0_pc), 32'd1);
      tick(idle);
      chk("redir_flushcnt", 32'(u0_flush), 32'd1);
      chk("redir_stallcnt", 32'(u0_stall), 32'd0);

      // Memory wait with redirect pending; redirect applied in the ready cycle
      s = rnd(0); s.rst = 1'b1; tick(s);
      for (int i = 0; i < 4; i++) begin
         tick(mk(0, 1, 2, 1, 3, 0, 1, 1, 0));
         chk("memwait_frozen", 32'({u0_pc, u0_ifw, u0_iff, u0_idf, u0_exw, u0_wbw}), 32'd0);
      end
      tick(mk(0, 1, 2, 1, 3, 0, 1, 1, 1));
      chk("memready_redirect", 32'({u0_iff, u0_idf, u0_pc}), 32'b111);
      tick(idle);
      chk("memwait_stallcnt", 32'(u0_stall), 32'd4);
      chk("memwait_flushcnt", 32'(u0_flush), 32'd1);

      // Watchdog on the small instance: sets after the 3rd wait cycle, sticky until reset
      s = rnd(0); s.rst = 1'b1; tick(s);
      for (int i = 0; i < 3; i++) tick(mk(0, 1, 2, 1, 3, 0, 0, 1, 0));
      chk("wdog_not_yet", 32'(u1_err), 32'd0);
      tick(mk(0, 1, 2, 1, 3, 0, 0, 1, 0));
      tick(mk(0, 1, 2, 1, 3, 0, 0, 1, 0));
      chk("wdog_set", 32'(u1_err), 32'd1);
      chk("wdog_big_clear", 32'(u0_err), 32'd0);
      tick(mk(0, 1, 2, 1, 3, 0, 0, 1, 1));
      tick(idle);
      tick(idle);
      chk("wdog_sticky", 32'(u1_err), 32'd1);
      s = rnd(0); s.rst = 1'b1; tick(s);
      tick(idle);
      chk("wdog_reset_clears", 32'(u1_err), 32'd0);

      // Saturation: 20 load-use stalls
      for (int i = 0; i < 20; i++) tick(mk(0, 7, 0, 0, 7, 1, 0, 0, 1));
      tick(idle);
      chk("sat_small", 32'(u1_stall), 32'd15);
      chk("sat_big", 32'(u0_stall), 32'd20);

      // Random traffic against the model
      for (int i = 0; i < 600; i++) tick(rnd(1));

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
